// File: rtl/bcd_time_sequencer.sv
// Time-of-day sequencer: ripples BCD sec/min/hour through one shared external incrementer.
// Optional build macro BCD_SEQ_SEC_CLEAR_EN: setting min or hour also clears sec.
module bcd_time_sequencer #(
  parameter logic [15:0] MAX_SEC  = 16'h0059,
  parameter logic [15:0] MAX_MIN  = 16'h0059,
  parameter logic [15:0] MAX_HOUR = 16'h0023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        set_req,
  input  logic [1:0]  set_sel,
  input  logic [15:0] inc_out,
  output logic [15:0] inc_in,
  output logic [15:0] inc_max,
  output logic [15:0] sec,
  output logic [15:0] min,
  output logic [15:0] hour,
  output logic        busy,
  output logic        day_pulse,
  output logic        set_ack,
  output logic        tick_lost
);

  typedef enum logic [2:0] {S_IDLE, S_SEC, S_MIN, S_HOUR, S_SET} state_t;

  state_t     state, state_nxt;
  logic       tick_pend, tick_pend_nxt;
  logic       set_pend, set_pend_nxt;
  logic [1:0] sel_pend, sel_pend_nxt;
  logic [1:0] sel_act, sel_act_nxt;
  logic       lost_now;
  logic       wrap;

  assign wrap = (inc_out == 16'h0000);

  always_comb begin
    state_nxt     = state;
    tick_pend_nxt = tick_pend | tick_1hz;
    lost_now      = tick_pend & tick_1hz;
    set_pend_nxt  = set_pend | set_req;
    sel_pend_nxt  = set_req ? set_sel : sel_pend;
    sel_act_nxt   = sel_act;
    case (state)
      S_IDLE: begin
        // A tick always wins; an arriving tick is served directly instead of being queued.
        if (tick_pend || tick_1hz) begin
          state_nxt     = S_SEC;
          tick_pend_nxt = tick_pend & tick_1hz;
          lost_now      = 1'b0;
        end else if (set_pend || set_req) begin
          state_nxt    = S_SET;
          set_pend_nxt = 1'b0;
          sel_act_nxt  = set_req ? set_sel : sel_pend;
        end
      end
      S_SEC:   state_nxt = wrap ? S_MIN : S_IDLE;
      S_MIN:   state_nxt = wrap ? S_HOUR : S_IDLE;
      S_HOUR:  state_nxt = S_IDLE;
      S_SET:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inc_in  = 16'h0000;
    inc_max = 16'h0000;
    case (state)
      S_SEC:  begin inc_in = sec;  inc_max = MAX_SEC;  end
      S_MIN:  begin inc_in = min;  inc_max = MAX_MIN;  end
      S_HOUR: begin inc_in = hour; inc_max = MAX_HOUR; end
      S_SET: begin
        case (sel_act)
          2'd0:    begin inc_in = sec;  inc_max = MAX_SEC;  end
          2'd1:    begin inc_in = min;  inc_max = MAX_MIN;  end
          2'd2:    begin inc_in = hour; inc_max = MAX_HOUR; end
          default: begin inc_in = 16'h0000; inc_max = 16'h0000; end
        endcase
      end
      default: begin inc_in = 16'h0000; inc_max = 16'h0000; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      tick_pend <= 1'b0;
      set_pend  <= 1'b0;
      sel_pend  <= 2'd0;
      sel_act   <= 2'd0;
      tick_lost <= 1'b0;
      day_pulse <= 1'b0;
      set_ack   <= 1'b0;
      sec       <= 16'h0000;
      min       <= 16'h0000;
      hour      <= 16'h0000;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      tick_pend <= tick_pend_nxt;
      set_pend  <= set_pend_nxt;
      sel_pend  <= sel_pend_nxt;
      sel_act   <= sel_act_nxt;
      tick_lost <= tick_lost | lost_now;
      day_pulse <= (state == S_HOUR) && wrap;
      set_ack   <= (state == S_SET);
      case (state)
        S_SEC:  sec  <= inc_out;
        S_MIN:  min  <= inc_out;
        S_HOUR: hour <= inc_out;
        S_SET: begin
          case (sel_act)
            2'd0:    sec  <= inc_out;
            2'd1:    min  <= inc_out;
            2'd2:    hour <= inc_out;
            default: ;
          endcase
`ifdef BCD_SEQ_SEC_CLEAR_EN
          if (sel_act == 2'd1 || sel_act == 2'd2)
            sec <= 16'h0000;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_time_sequencer.sv
// Directed bench for bcd_time_sequencer with a behavioural BCD incrementer model.
module tb_bcd_time_sequencer;

  logic        clk = 1'b0;
  logic        rst, tick_1hz, set_req;
  logic [1:0]  set_sel;
  logic [15:0] inc_out, inc_in, inc_max, sec, min, hour;
  logic        busy, day_pulse, set_ack, tick_lost;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_time_sequencer dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .set_req(set_req), .set_sel(set_sel),
    .inc_out(inc_out), .inc_in(inc_in), .inc_max(inc_max),
    .sec(sec), .min(min), .hour(hour), .busy(busy), .day_pulse(day_pulse),
    .set_ack(set_ack), .tick_lost(tick_lost)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v, input logic [15:0] mx);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == mx) return 16'h0000;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb inc_out = bcd_inc(inc_in, inc_max);

  typedef struct {
    bit          r, t, s;
    logic [1:0]  sl;
    logic [15:0] e_sec, e_min, e_hour;
    bit          e_busy, e_day, e_ack, e_lost;
    logic [15:0] e_max;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [127:0] snap();
    return {sec, min, hour, busy, day_pulse, set_ack, tick_lost, inc_max};
  endfunction

  function automatic logic [127:0] mk(input logic [15:0] s, m, h, input bit b, d, a, l,
                                      input logic [15:0] mx);
    return {s, m, h, b, d, a, l, mx};
  endfunction

  task automatic step(input bit r, t, s, input logic [1:0] sl);
    rst = r; tick_1hz = t; set_req = s; set_sel = sl;
    @(posedge clk);
    #1;
    rst = 0; tick_1hz = 0; set_req = 0; set_sel = 2'd0;
  endtask

  task automatic do_sets(input logic [1:0] sl, input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, sl);
      step(0, 0, 0, 2'd0);
    end
  endtask

  // Hours first, then minutes, then seconds so an optional sec clear cannot undo the preload.
  task automatic preload(input int h, input int m, input int s);
    step(1, 0, 0, 2'd0);
    do_sets(2'd2, h);
    do_sets(2'd1, m);
    do_sets(2'd0, s);
  endtask

  initial begin
    logic [15:0] exp_sec;
    rst = 1; tick_1hz = 0; set_req = 0; set_sel = 2'd0;
    @(posedge clk); #1;

    //          r t s sl  sec      min      hour    busy day ack lost max
    tbl[0]  = '{1,0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,0,0, 16'h0000};
    tbl[1]  = '{0,0,1,1, 16'h0000,16'h0000,16'h0000, 1,0,0,0, 16'h0059};
    tbl[2]  = '{0,0,0,0, 16'h0000,16'h0001,16'h0000, 0,0,1,0, 16'h0000};
    tbl[3]  = '{0,0,1,2, 16'h0000,16'h0001,16'h0000, 1,0,0,0, 16'h0023};
    tbl[4]  = '{0,0,0,0, 16'h0000,16'h0001,16'h0001, 0,0,1,0, 16'h0000};
    tbl[5]  = '{0,0,1,3, 16'h0000,16'h0001,16'h0001, 1,0,0,0, 16'h0000};
    tbl[6]  = '{0,0,0,0, 16'h0000,16'h0001,16'h0001, 0,0,1,0, 16'h0000};
    tbl[7]  = '{0,1,0,0, 16'h0000,16'h0001,16'h0001, 1,0,0,0, 16'h0059};
    tbl[8]  = '{0,0,0,0, 16'h0001,16'h0001,16'h0001, 0,0,0,0, 16'h0000};
    tbl[9]  = '{0,1,1,0, 16'h0001,16'h0001,16'h0001, 1,0,0,0, 16'h0059};
    tbl[10] = '{0,0,0,0, 16'h0002,16'h0001,16'h0001, 0,0,0,0, 16'h0000};
    tbl[11] = '{0,0,0,0, 16'h0002,16'h0001,16'h0001, 1,0,0,0, 16'h0059};
    tbl[12] = '{0,0,0,0, 16'h0003,16'h0001,16'h0001, 0,0,1,0, 16'h0000};
    tbl[13] = '{0,0,0,0, 16'h0003,16'h0001,16'h0001, 0,0,0,0, 16'h0000};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].sl);
      chk($sformatf("vec%0d", i), snap(),
          mk(tbl[i].e_sec, tbl[i].e_min, tbl[i].e_hour, tbl[i].e_busy, tbl[i].e_day,
             tbl[i].e_ack, tbl[i].e_lost, tbl[i].e_max));
    end

    // Full day rollover from 23:59:59
    preload(23, 59, 59);
    chk("preload", {sec, min, hour}, {16'h0059, 16'h0059, 16'h0023});
    step(0, 1, 0, 2'd0);
    chk("roll_k1", snap(), mk(16'h0059, 16'h0059, 16'h0023, 1, 0, 0, 0, 16'h0059));
    step(0, 0, 0, 2'd0);
    chk("roll_k2", snap(), mk(16'h0000, 16'h0059, 16'h0023, 1, 0, 0, 0, 16'h0059));
    step(0, 0, 0, 2'd0);
    chk("roll_k3", snap(), mk(16'h0000, 16'h0000, 16'h0023, 1, 0, 0, 0, 16'h0023));
    step(0, 0, 0, 2'd0);
    chk("roll_k4", snap(), mk(16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000));
    step(0, 0, 0, 2'd0);
    chk("roll_k5", snap(), mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000));

    // Set wraps minutes without carrying into hours
    preload(3, 59, 5);
`ifdef BCD_SEQ_SEC_CLEAR_EN
    exp_sec = 16'h0000;
`else
    exp_sec = 16'h0005;
`endif
    step(0, 0, 1, 2'd1);
    step(0, 0, 0, 2'd0);
    chk("set_min_wrap", snap(), mk(exp_sec, 16'h0000, 16'h0003, 0, 0, 1, 0, 16'h0000));
    step(0, 0, 0, 2'd0);
    chk("set_ack_once", {set_ack, hour}, {1'b0, 16'h0003});

    // Tick and hour set together at 00:00:59
    preload(0, 0, 59);
    step(0, 1, 1, 2'd2);
    step(0, 0, 0, 2'd0);
    step(0, 0, 0, 2'd0);
    chk("arb_k3", snap(), mk(16'h0000, 16'h0001, 16'h0000, 0, 0, 0, 0, 16'h0000));
    step(0, 0, 0, 2'd0);
    chk("arb_k4", {busy, inc_max}, {1'b1, 16'h0023});
    step(0, 0, 0, 2'd0);
    chk("arb_k5", snap(), mk(16'h0000, 16'h0001, 16'h0001, 0, 0, 1, 0, 16'h0000));

    // Overlapping ticks during a ripple
    preload(0, 0, 59);
    step(0, 1, 0, 2'd0);
    step(0, 1, 0, 2'd0);
    chk("lost_none", tick_lost, 1'b0);
    step(0, 1, 0, 2'd0);
    chk("lost_set", tick_lost, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 2'd0);
    chk("lost_sticky", tick_lost, 1'b1);
    step(1, 0, 0, 2'd0);
    chk("lost_rst", tick_lost, 1'b0);

    // Reset in the MIN state of a full ripple
    preload(23, 59, 59);
    step(0, 1, 0, 2'd0);
    step(0, 0, 0, 2'd0);
    chk("abort_in_min", {busy, inc_max}, {1'b1, 16'h0059});
    step(1, 0, 0, 2'd0);
    chk("abort_k3", snap(), mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000));
    step(0, 0, 0, 2'd0);
    chk("abort_k4", snap(), mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_time_sequencer.md
# bcd_time_sequencer

Time-of-day controller for the digital clock core. Holds the seconds, minutes and hours BCD registers and sequences one shared, external `bcd_increment_16bit` instance through them. It ripples carries on each 1 Hz tick and arbitrates user set requests onto the same incrementer. It sits between the tick divider and the display/alarm logic.

## Interface
Parameters:
- `MAX_SEC`, default `16'h0059`: seconds wrap value (BCD).
- `MAX_MIN`, default `16'h0059`: minutes wrap value (BCD).
- `MAX_HOUR`, default `16'h0023`: hours wrap value (BCD).

Ports:
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick_1hz` input 1: one-cycle pulse requesting a time advance.
- `set_req` input 1: one-cycle pulse requesting a single increment of the selected field.
- `set_sel` input 2: field for `set_req`; 0 = sec, 1 = min, 2 = hour, 3 = none.
- `inc_out` input 16: result from the shared incrementer.
- `inc_in` output 16: operand to the shared incrementer.
- `inc_max` output 16: wrap value to the shared incrementer.
- `sec`, `min`, `hour` output 16 each: current BCD time.
- `busy` output 1: FSM not in IDLE.
- `day_pulse` output 1: one-cycle pulse when hours wrap to `0000`.
- `set_ack` output 1: one-cycle pulse when a set request completes.
- `tick_lost` output 1: sticky flag, set when a tick is dropped.

## Operation
- FSM states: IDLE, SEC, MIN, HOUR, SET. Each non-IDLE state lasts exactly one cycle.
- The incrementer is combinational and external. The block drives it as follows:
  - In SEC, MIN and HOUR: `inc_in` = the field for that state; `inc_max` = the matching MAX parameter.
  - In SET: `inc_in` and `inc_max` select the latched field and its MAX.
  - In IDLE: both outputs are `16'h0000`.
- Field update: at the end of each increment state, field <= `inc_out`.
- Carry: a field has wrapped when `inc_out == 16'h0000`.
  - SEC: wrap -> MIN, else -> IDLE.
  - MIN: wrap -> HOUR, else -> IDLE.
  - HOUR: always -> IDLE. If hours wrapped, `day_pulse` is registered high for one cycle.
- SET: increments only the latched field, with no carry into higher fields. Then -> IDLE with `set_ack` high for one cycle. `set_sel = 3` passes through SET with no field change and still acks.
- Pending latches:
  - A `tick_1hz` or `set_req` seen in any state (including IDLE) sets a one-deep pending bit.
  - `set_sel` is captured together with its `set_req`.
  - A tick arriving while the tick-pending bit is already set is dropped and sets `tick_lost`.
  - A second `set_req` while one is pending overwrites the pending `set_sel`.
- IDLE arbitration: a pending or arriving tick has priority over a set, so the set waits. A tick and a set in the same IDLE cycle -> SEC first, SET after the return to IDLE.
- Reset values: `sec`, `min` and `hour` = `0000`; state IDLE; all pulses, pending bits, `busy` and `tick_lost` = 0. Reset mid-sequence aborts the sequence. A partially rippled carry is discarded with it, and all fields clear.

## Timing
- `tick_1hz` high in IDLE cycle k:
  - SEC in cycle k+1; `sec` updated, visible in cycle k+2.
  - On a seconds wrap: `min` visible in k+3.
  - On a minutes wrap as well: `hour` and `day_pulse` visible in k+4.
- A full ripple occupies at most 3 busy cycles, so ticks never overlap in normal operation.
- `set_req` in IDLE cycle k (no tick): SET in k+1; field and `set_ack` visible in k+2.
- `busy` is registered: high exactly during the non-IDLE cycles.

## Configuration
- `BCD_SEQ_SEC_CLEAR_EN`:
  - Defined: a completed SET on min or hour also clears `sec` to `0000` in the same edge.
  - Undefined: SET touches only the selected field.

## Test plan
- Reset, then apply one tick -> `sec` = `0001` two cycles after the tick; `busy` high for one cycle; `inc_max` = `0059` during SEC.
- Preload 23:59:59 via set requests, then tick -> time reads `0000`/`0000`/`0000` at k+4; `day_pulse` is a single cycle at k+4.
- `min` = `0059`, `set_req` with sel=1 -> `min` = `0000`, `hour` unchanged, `set_ack` one cycle. With `BCD_SEQ_SEC_CLEAR_EN` defined, `sec` also reads `0000`.
- Tick and `set_req` (sel=2) in the same cycle at 00:00:59 -> seconds/minutes ripple completes first, then `hour` = `0001`. Final reading 01:01:00.
- Ticks on two consecutive cycles while busy, then a third tick before the pending one is served -> `tick_lost` = 1 and stays set until `rst`.
- Assert `rst` in the MIN state of a ripple -> next cycle all fields `0000`, IDLE, no `day_pulse`.
